// File: rtl/axi_mux2_if.sv
// axi_channel: AXI4 channel bundle (id/addr/len/size/burst/user per address
// channel) shared by the masters, the 2:1 mux and the downstream ID downsizer.
interface axi_channel #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 1
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ID_WIDTH-1:0]       aw_id;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [USER_WIDTH-1:0]     aw_user;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      w_last;
    logic [USER_WIDTH-1:0]     w_user;

    logic                      b_valid;
    logic                      b_ready;
    logic [ID_WIDTH-1:0]       b_id;
    logic [1:0]                b_resp;
    logic [USER_WIDTH-1:0]     b_user;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ID_WIDTH-1:0]       ar_id;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [USER_WIDTH-1:0]     ar_user;

    logic                      r_valid;
    logic                      r_ready;
    logic [ID_WIDTH-1:0]       r_id;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [USER_WIDTH-1:0]     r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );
endinterface

// File: rtl/axi_mux2.sv
// axi_mux2: merges two AXI masters onto one port. The output ID gains an MSB
// naming the issuing master; AW/AR are arbitrated into a forward register,
// W follows AW grant order via a small FIFO, B/R are routed by the ID MSB.
// Optional feature macro: AXI_MUX2_RR_EN (round-robin tie-break per channel;
// without it m0 always wins ties).

// Arbitrated address channel stage: 2:1 grant plus one forward register.
module axi_mux2_addr_stage #(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 accept_ok_i,
    input  logic                 req0_i,
    input  logic                 req1_i,
    input  logic [PAYLOAD_W-1:0] pay0_i,
    input  logic [PAYLOAD_W-1:0] pay1_i,
    input  logic                 out_ready_i,
    output logic                 ready0_o,
    output logic                 ready1_o,
    output logic                 out_valid_o,
    output logic [PAYLOAD_W:0]   out_pay_o
);
    logic               full_q, full_d;
    logic [PAYLOAD_W:0] pay_q, pay_d;
    logic               load_ok;
    logic               sel;
    logic               hs;

`ifdef AXI_MUX2_RR_EN
    logic prio_q, prio_d;

    // Priority moves to the other master after every grant.
    always_comb begin
        prio_d = prio_q;
        if (hs) begin
            prio_d = ~sel;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign sel = req1_i & (~req0_i | prio_q);
`else
    assign sel = req1_i & ~req0_i;
`endif

    assign load_ok     = (~full_q | out_ready_i) & accept_ok_i;
    assign ready0_o    = load_ok & req0_i & ~sel;
    assign ready1_o    = load_ok & req1_i & sel;
    assign hs          = ready0_o | ready1_o;
    assign out_valid_o = full_q;
    assign out_pay_o   = pay_q;

    // Load on a granted handshake, otherwise drain when the slave accepts.
    always_comb begin
        full_d = full_q;
        pay_d  = pay_q;
        if (hs) begin
            full_d = 1'b1;
            pay_d  = {sel, (sel ? pay1_i : pay0_i)};
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    // Forward register with async clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q <= 1'b0;
            pay_q  <= '0;
        end else begin
            full_q <= full_d;
            pay_q  <= pay_d;
        end
    end
endmodule

module axi_mux2 #(
    parameter int unsigned W_FIFO_DEPTH = 4
) (
    input logic        clk,
    input logic        rstn,
    axi_channel.slave  m0,
    axi_channel.slave  m1,
    axi_channel.master s
);
    localparam int unsigned M_ID_W  = m0.ID_WIDTH;
    localparam int unsigned M1_ID_W = m1.ID_WIDTH;
    localparam int unsigned S_ID_W  = s.ID_WIDTH;
    localparam int unsigned ADDR_W  = m0.ADDR_WIDTH;
    localparam int unsigned DATA_W  = m0.DATA_WIDTH;
    localparam int unsigned USER_W  = m0.USER_WIDTH;
    localparam int unsigned A_PAY_W = M_ID_W + ADDR_W + 13 + USER_W;
    localparam int unsigned PTR_W   = $clog2(W_FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    // Elaboration-time configuration checks.
    if (M1_ID_W != M_ID_W) begin : g_err_mid
        $fatal(1, "axi_mux2: m0/m1 ID_WIDTH differ");
    end
    if (S_ID_W != M_ID_W + 1) begin : g_err_sid
        $fatal(1, "axi_mux2: s.ID_WIDTH must be m0.ID_WIDTH+1");
    end
    if (m1.ADDR_WIDTH != ADDR_W || s.ADDR_WIDTH != ADDR_W) begin : g_err_addr
        $fatal(1, "axi_mux2: ADDR_WIDTH differs between ports");
    end
    if (m1.DATA_WIDTH != DATA_W || s.DATA_WIDTH != DATA_W) begin : g_err_data
        $fatal(1, "axi_mux2: DATA_WIDTH differs between ports");
    end
    if (m1.USER_WIDTH != USER_W || s.USER_WIDTH != USER_W) begin : g_err_user
        $fatal(1, "axi_mux2: USER_WIDTH differs between ports");
    end
    if (W_FIFO_DEPTH < 2 || (W_FIFO_DEPTH & (W_FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $fatal(1, "axi_mux2: W_FIFO_DEPTH must be a power of two >= 2");
    end

    logic [W_FIFO_DEPTH-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    w_head;
    logic                    aw_accept_ok;
    logic                    aw_push;
    logic                    aw_push_src;
    logic                    w_pop;
    logic [A_PAY_W:0]        aw_out;
    logic [A_PAY_W:0]        ar_out;

    assign fifo_full    = (cnt_q == CNT_W'(W_FIFO_DEPTH));
    assign fifo_empty   = (cnt_q == '0);
    assign w_head       = fifo_q[rd_ptr_q];
    assign aw_accept_ok = ~fifo_full;

    // AW: arbitrate, register, and record the winner for W steering.
    axi_mux2_addr_stage #(.PAYLOAD_W(A_PAY_W)) u_aw (
        .clk         (clk),
        .rstn        (rstn),
        .accept_ok_i (aw_accept_ok),
        .req0_i      (m0.aw_valid),
        .req1_i      (m1.aw_valid),
        .pay0_i      ({m0.aw_id, m0.aw_addr, m0.aw_len, m0.aw_size, m0.aw_burst, m0.aw_user}),
        .pay1_i      ({m1.aw_id, m1.aw_addr, m1.aw_len, m1.aw_size, m1.aw_burst, m1.aw_user}),
        .out_ready_i (s.aw_ready),
        .ready0_o    (m0.aw_ready),
        .ready1_o    (m1.aw_ready),
        .out_valid_o (s.aw_valid),
        .out_pay_o   (aw_out)
    );
    assign {s.aw_id, s.aw_addr, s.aw_len, s.aw_size, s.aw_burst, s.aw_user} = aw_out;

    // AR: same stage, never blocked by W bookkeeping.
    axi_mux2_addr_stage #(.PAYLOAD_W(A_PAY_W)) u_ar (
        .clk         (clk),
        .rstn        (rstn),
        .accept_ok_i (1'b1),
        .req0_i      (m0.ar_valid),
        .req1_i      (m1.ar_valid),
        .pay0_i      ({m0.ar_id, m0.ar_addr, m0.ar_len, m0.ar_size, m0.ar_burst, m0.ar_user}),
        .pay1_i      ({m1.ar_id, m1.ar_addr, m1.ar_len, m1.ar_size, m1.ar_burst, m1.ar_user}),
        .out_ready_i (s.ar_ready),
        .ready0_o    (m0.ar_ready),
        .ready1_o    (m1.ar_ready),
        .out_valid_o (s.ar_valid),
        .out_pay_o   (ar_out)
    );
    assign {s.ar_id, s.ar_addr, s.ar_len, s.ar_size, s.ar_burst, s.ar_user} = ar_out;

    assign aw_push     = (m0.aw_valid & m0.aw_ready) | (m1.aw_valid & m1.aw_ready);
    assign aw_push_src = m1.aw_ready;
    assign w_pop       = s.w_valid & s.w_ready & s.w_last;

    // W-order FIFO next state: push grant owner, pop on last beat.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (aw_push) begin
            fifo_d[wr_ptr_q] = aw_push_src;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({aw_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // W-order FIFO registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // W steering from the FIFO head; nothing flows while it is empty.
    assign s.w_valid  = ~fifo_empty & (w_head ? m1.w_valid : m0.w_valid);
    assign s.w_data   = w_head ? m1.w_data : m0.w_data;
    assign s.w_strb   = w_head ? m1.w_strb : m0.w_strb;
    assign s.w_last   = w_head ? m1.w_last : m0.w_last;
    assign s.w_user   = w_head ? m1.w_user : m0.w_user;
    assign m0.w_ready = ~fifo_empty & ~w_head & s.w_ready;
    assign m1.w_ready = ~fifo_empty & w_head & s.w_ready;

    // B routing by response ID MSB.
    assign m0.b_valid = s.b_valid & ~s.b_id[M_ID_W];
    assign m1.b_valid = s.b_valid & s.b_id[M_ID_W];
    assign m0.b_id    = s.b_id[M_ID_W-1:0];
    assign m1.b_id    = s.b_id[M_ID_W-1:0];
    assign m0.b_resp  = s.b_resp;
    assign m1.b_resp  = s.b_resp;
    assign m0.b_user  = s.b_user;
    assign m1.b_user  = s.b_user;
    assign s.b_ready  = s.b_id[M_ID_W] ? m1.b_ready : m0.b_ready;

    // R routing by response ID MSB.
    assign m0.r_valid = s.r_valid & ~s.r_id[M_ID_W];
    assign m1.r_valid = s.r_valid & s.r_id[M_ID_W];
    assign m0.r_id    = s.r_id[M_ID_W-1:0];
    assign m1.r_id    = s.r_id[M_ID_W-1:0];
    assign m0.r_data  = s.r_data;
    assign m1.r_data  = s.r_data;
    assign m0.r_resp  = s.r_resp;
    assign m1.r_resp  = s.r_resp;
    assign m0.r_last  = s.r_last;
    assign m1.r_last  = s.r_last;
    assign m0.r_user  = s.r_user;
    assign m1.r_user  = s.r_user;
    assign s.r_ready  = s.r_id[M_ID_W] ? m1.r_ready : m0.r_ready;
endmodule

// File: tb/tb_axi_mux2.sv
// tb_axi_mux2: directed bench for the 2:1 AXI mux (single write, tie
// arbitration, W FIFO full/wrap, W steering, R routing, AR stall + reset).
`timescale 1ns/1ps
module tb_axi_mux2;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .USER_WIDTH(2)) m0_if ();
    axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .USER_WIDTH(2)) m1_if ();
    axi_channel #(.ID_WIDTH(5), .ADDR_WIDTH(16), .DATA_WIDTH(16), .USER_WIDTH(2)) s_if ();

    axi_mux2 #(.W_FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .m0   (m0_if),
        .m1   (m1_if),
        .s    (s_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        m0_if.aw_valid = 1'b0; m0_if.aw_id = '0; m0_if.aw_addr = '0; m0_if.aw_len = '0;
        m0_if.aw_size = '0; m0_if.aw_burst = '0; m0_if.aw_user = '0;
        m0_if.w_valid = 1'b0; m0_if.w_data = '0; m0_if.w_strb = '0; m0_if.w_last = 1'b0;
        m0_if.w_user = '0; m0_if.b_ready = 1'b0; m0_if.r_ready = 1'b0;
        m0_if.ar_valid = 1'b0; m0_if.ar_id = '0; m0_if.ar_addr = '0; m0_if.ar_len = '0;
        m0_if.ar_size = '0; m0_if.ar_burst = '0; m0_if.ar_user = '0;
        m1_if.aw_valid = 1'b0; m1_if.aw_id = '0; m1_if.aw_addr = '0; m1_if.aw_len = '0;
        m1_if.aw_size = '0; m1_if.aw_burst = '0; m1_if.aw_user = '0;
        m1_if.w_valid = 1'b0; m1_if.w_data = '0; m1_if.w_strb = '0; m1_if.w_last = 1'b0;
        m1_if.w_user = '0; m1_if.b_ready = 1'b0; m1_if.r_ready = 1'b0;
        m1_if.ar_valid = 1'b0; m1_if.ar_id = '0; m1_if.ar_addr = '0; m1_if.ar_len = '0;
        m1_if.ar_size = '0; m1_if.ar_burst = '0; m1_if.ar_user = '0;
        s_if.aw_ready = 1'b0; s_if.w_ready = 1'b0; s_if.ar_ready = 1'b0;
        s_if.b_valid = 1'b0; s_if.b_id = '0; s_if.b_resp = '0; s_if.b_user = '0;
        s_if.r_valid = 1'b0; s_if.r_id = '0; s_if.r_data = '0; s_if.r_resp = '0;
        s_if.r_last = 1'b0; s_if.r_user = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] tie_k;
        logic [5:0] r_k;
        logic [5:0] r_last;
        logic       k;
        logic [15:0] exp_data;

        // ---- reset state
        do_reset();
        check("rst_s_aw_valid", 32'(s_if.aw_valid), 32'h0);
        check("rst_s_ar_valid", 32'(s_if.ar_valid), 32'h0);
        check("rst_s_w_valid", 32'(s_if.w_valid), 32'h0);
        check("rst_s_b_ready", 32'(s_if.b_ready), 32'h0);
        check("rst_s_r_ready", 32'(s_if.r_ready), 32'h0);
        check("rst_m0_aw_ready", 32'(m0_if.aw_ready), 32'h0);
        check("rst_m1_ar_ready", 32'(m1_if.ar_ready), 32'h0);
        check("rst_m0_w_ready", 32'(m0_if.w_ready), 32'h0);
        check("rst_m1_b_valid", 32'(m1_if.b_valid), 32'h0);
        check("rst_m0_r_valid", 32'(m0_if.r_valid), 32'h0);

        // ---- single write from m1
        s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1;
        m1_if.aw_valid = 1'b1; m1_if.aw_id = 4'd3; m1_if.aw_addr = 16'h1234;
        m1_if.aw_len = 8'd1; m1_if.aw_size = 3'd1; m1_if.aw_burst = 2'd1; m1_if.aw_user = 2'd2;
        settle();
        check("wr_m1_aw_ready", 32'(m1_if.aw_ready), 32'h1);
        check("wr_m0_aw_ready", 32'(m0_if.aw_ready), 32'h0);
        tick();
        m1_if.aw_valid = 1'b0;
        settle();
        check("wr_s_aw_valid", 32'(s_if.aw_valid), 32'h1);
        check("wr_s_aw_id", 32'(s_if.aw_id), 32'h13);
        check("wr_s_aw_addr", 32'(s_if.aw_addr), 32'h1234);
        check("wr_s_aw_len", 32'(s_if.aw_len), 32'h1);
        check("wr_s_aw_size", 32'(s_if.aw_size), 32'h1);
        check("wr_s_aw_burst", 32'(s_if.aw_burst), 32'h1);
        check("wr_s_aw_user", 32'(s_if.aw_user), 32'h2);
        m1_if.w_valid = 1'b1; m1_if.w_data = 16'h00A1; m1_if.w_last = 1'b0; m1_if.w_strb = 2'd3;
        m0_if.w_valid = 1'b1; m0_if.w_data = 16'hDEAD;
        settle();
        check("wr_b1_s_w_valid", 32'(s_if.w_valid), 32'h1);
        check("wr_b1_s_w_data", 32'(s_if.w_data), 32'h00A1);
        check("wr_b1_s_w_last", 32'(s_if.w_last), 32'h0);
        check("wr_b1_m1_w_ready", 32'(m1_if.w_ready), 32'h1);
        check("wr_b1_m0_w_ready", 32'(m0_if.w_ready), 32'h0);
        tick();
        m1_if.w_data = 16'h00A2; m1_if.w_last = 1'b1; m1_if.w_user = 2'd2;
        settle();
        check("wr_b2_s_w_data", 32'(s_if.w_data), 32'h00A2);
        check("wr_b2_s_w_last", 32'(s_if.w_last), 32'h1);
        check("wr_b2_s_w_user", 32'(s_if.w_user), 32'h2);
        check("wr_b2_s_w_strb", 32'(s_if.w_strb), 32'h3);
        tick();
        m1_if.w_valid = 1'b0;
        settle();
        check("wr_empty_s_w_valid", 32'(s_if.w_valid), 32'h0);
        check("wr_empty_m0_w_ready", 32'(m0_if.w_ready), 32'h0);
        check("wr_aw_drained", 32'(s_if.aw_valid), 32'h0);
        m0_if.w_valid = 1'b0;
        s_if.b_valid = 1'b1; s_if.b_id = 5'h13; s_if.b_resp = 2'd2; s_if.b_user = 2'd1;
        m1_if.b_ready = 1'b1;
        settle();
        check("b_m1_valid", 32'(m1_if.b_valid), 32'h1);
        check("b_m1_id", 32'(m1_if.b_id), 32'h3);
        check("b_m1_resp", 32'(m1_if.b_resp), 32'h2);
        check("b_m1_user", 32'(m1_if.b_user), 32'h1);
        check("b_m0_valid", 32'(m0_if.b_valid), 32'h0);
        check("b_s_ready", 32'(s_if.b_ready), 32'h1);
        tick();
        s_if.b_valid = 1'b0; m1_if.b_ready = 1'b0;

        // ---- AW tie arbitration
        do_reset();
`ifdef AXI_MUX2_RR_EN
        tie_k = 4'b1010;
`else
        tie_k = 4'b0000;
`endif
        s_if.aw_ready = 1'b1;
        m0_if.aw_valid = 1'b1; m0_if.aw_id = 4'd1; m0_if.aw_addr = 16'h0100;
        m1_if.aw_valid = 1'b1; m1_if.aw_id = 4'd2; m1_if.aw_addr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("tie_m0_aw_ready", 32'(m0_if.aw_ready), 32'(!tie_k[i]));
            check("tie_m1_aw_ready", 32'(m1_if.aw_ready), 32'(tie_k[i]));
            tick();
            check("tie_s_aw_id", 32'(s_if.aw_id), tie_k[i] ? 32'h12 : 32'h01);
            check("tie_s_aw_addr", 32'(s_if.aw_addr), tie_k[i] ? 32'h0200 : 32'h0100);
        end
        check("tie_full_m0_aw_ready", 32'(m0_if.aw_ready), 32'h0);
        check("tie_full_m1_aw_ready", 32'(m1_if.aw_ready), 32'h0);

        // ---- W FIFO full, stall, release, wrap
        do_reset();
        s_if.aw_ready = 1'b1;
        m0_if.aw_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_if.aw_id = 4'(i);
            settle();
            check("full_fill_aw_ready", 32'(m0_if.aw_ready), 32'h1);
            tick();
        end
        m0_if.aw_id = 4'd4;
        settle();
        check("full_stall0_aw_ready", 32'(m0_if.aw_ready), 32'h0);
        tick();
        check("full_stall1_aw_ready", 32'(m0_if.aw_ready), 32'h0);
        s_if.w_ready = 1'b1;
        m0_if.w_valid = 1'b1; m0_if.w_last = 1'b1; m0_if.w_data = 16'h0050;
        settle();
        check("full_pop_s_w_valid", 32'(s_if.w_valid), 32'h1);
        check("full_pop_m0_w_ready", 32'(m0_if.w_ready), 32'h1);
        check("full_pop_aw_ready", 32'(m0_if.aw_ready), 32'h0);
        tick();
        m0_if.w_valid = 1'b0;
        settle();
        check("full_after_aw_ready", 32'(m0_if.aw_ready), 32'h1);
        tick();
        m0_if.aw_valid = 1'b0;
        settle();
        check("full_fifth_aw_valid", 32'(s_if.aw_valid), 32'h1);
        check("full_fifth_aw_id", 32'(s_if.aw_id), 32'h04);
        m0_if.w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("full_drain_w_valid", 32'(s_if.w_valid), 32'h1);
            tick();
        end
        settle();
        check("full_drained_w_valid", 32'(s_if.w_valid), 32'h0);
        m0_if.w_valid = 1'b0;

        // ---- W steering in AW order m0, m1, m0
        do_reset();
        s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1;
        m0_if.aw_valid = 1'b1; m0_if.aw_id = 4'd1;
        settle();
        check("st_aw0_ready", 32'(m0_if.aw_ready), 32'h1);
        tick();
        m0_if.aw_valid = 1'b0; m1_if.aw_valid = 1'b1; m1_if.aw_id = 4'd2;
        settle();
        check("st_aw1_ready", 32'(m1_if.aw_ready), 32'h1);
        tick();
        m1_if.aw_valid = 1'b0; m0_if.aw_valid = 1'b1; m0_if.aw_id = 4'd3;
        settle();
        check("st_aw2_ready", 32'(m0_if.aw_ready), 32'h1);
        tick();
        m0_if.aw_valid = 1'b0;
        m0_if.w_valid = 1'b1; m0_if.w_data = 16'h0010; m0_if.w_last = 1'b1;
        m1_if.w_valid = 1'b1; m1_if.w_data = 16'h0020; m1_if.w_last = 1'b0;
        settle();
        check("st_a_data", 32'(s_if.w_data), 32'h0010);
        check("st_a_last", 32'(s_if.w_last), 32'h1);
        check("st_a_m0_ready", 32'(m0_if.w_ready), 32'h1);
        check("st_a_m1_ready", 32'(m1_if.w_ready), 32'h0);
        tick();
        m0_if.w_data = 16'h0030; m1_if.w_valid = 1'b0;
        settle();
        check("st_b0_s_w_valid", 32'(s_if.w_valid), 32'h0);
        check("st_b0_m0_ready", 32'(m0_if.w_ready), 32'h0);
        tick();
        m1_if.w_valid = 1'b1;
        settle();
        check("st_b_data", 32'(s_if.w_data), 32'h0020);
        check("st_b_m1_ready", 32'(m1_if.w_ready), 32'h1);
        check("st_b_m0_ready", 32'(m0_if.w_ready), 32'h0);
        tick();
        m1_if.w_data = 16'h0021; m1_if.w_last = 1'b1;
        settle();
        check("st_c_data", 32'(s_if.w_data), 32'h0021);
        check("st_c_last", 32'(s_if.w_last), 32'h1);
        check("st_c_m0_ready", 32'(m0_if.w_ready), 32'h0);
        tick();
        m1_if.w_valid = 1'b0;
        settle();
        check("st_d_data", 32'(s_if.w_data), 32'h0030);
        check("st_d_m0_ready", 32'(m0_if.w_ready), 32'h1);
        check("st_d_m1_ready", 32'(m1_if.w_ready), 32'h0);
        tick();
        settle();
        check("st_empty_w_valid", 32'(s_if.w_valid), 32'h0);
        m0_if.w_valid = 1'b0;

        // ---- R routing, interleaved bursts {0,5} and {1,5}
        do_reset();
        m0_if.r_ready = 1'b1; m1_if.r_ready = 1'b1;
        r_k = 6'b101010;
        r_last = 6'b110000;
        for (int i = 0; i < 6; i++) begin
            k = r_k[i];
            exp_data = (k ? 16'h00B0 : 16'h00A0) + 16'(i / 2);
            s_if.r_valid = 1'b1; s_if.r_id = {k, 4'h5}; s_if.r_data = exp_data;
            s_if.r_last = r_last[i]; s_if.r_resp = {1'b0, k}; s_if.r_user = k ? 2'd2 : 2'd1;
            settle();
            check("r_own_valid", 32'(k ? m1_if.r_valid : m0_if.r_valid), 32'h1);
            check("r_other_valid", 32'(k ? m0_if.r_valid : m1_if.r_valid), 32'h0);
            check("r_id", 32'(k ? m1_if.r_id : m0_if.r_id), 32'h5);
            check("r_data", 32'(k ? m1_if.r_data : m0_if.r_data), 32'(exp_data));
            check("r_last", 32'(k ? m1_if.r_last : m0_if.r_last), 32'(r_last[i]));
            check("r_resp", 32'(k ? m1_if.r_resp : m0_if.r_resp), 32'(k));
            check("r_user", 32'(k ? m1_if.r_user : m0_if.r_user), k ? 32'h2 : 32'h1);
            check("r_s_ready", 32'(s_if.r_ready), 32'h1);
            tick();
        end
        s_if.r_valid = 1'b0;

        // ---- AR backpressure, then reset mid-stall
        do_reset();
        s_if.aw_ready = 1'b1;
        m0_if.aw_valid = 1'b1;
        m1_if.ar_valid = 1'b1; m1_if.ar_id = 4'd7; m1_if.ar_addr = 16'hABCD;
        m1_if.ar_len = 8'd3; m1_if.ar_size = 3'd2; m1_if.ar_burst = 2'd1; m1_if.ar_user = 2'd3;
        settle();
        check("ar_m1_ready", 32'(m1_if.ar_ready), 32'h1);
        tick();
        m1_if.ar_valid = 1'b0; m0_if.aw_valid = 1'b0;
        m0_if.ar_valid = 1'b1; m0_if.ar_addr = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("ar_stall_valid", 32'(s_if.ar_valid), 32'h1);
            check("ar_stall_id", 32'(s_if.ar_id), 32'h17);
            check("ar_stall_addr", 32'(s_if.ar_addr), 32'hABCD);
            check("ar_stall_len", 32'(s_if.ar_len), 32'h3);
            check("ar_stall_misc", 32'({s_if.ar_size, s_if.ar_burst, s_if.ar_user}), 32'h27);
            check("ar_stall_m0_ready", 32'(m0_if.ar_ready), 32'h0);
            tick();
        end
        idle_all();
        rstn = 1'b0;
        settle();
        check("ar_rst_async_valid", 32'(s_if.ar_valid), 32'h0);
        check("ar_rst_async_addr", 32'(s_if.ar_addr), 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        settle();
        check("post_rst_ar_valid", 32'(s_if.ar_valid), 32'h0);
        check("post_rst_aw_valid", 32'(s_if.aw_valid), 32'h0);
        m0_if.w_valid = 1'b1; m0_if.w_last = 1'b1; s_if.w_ready = 1'b1;
        settle();
        check("post_rst_fifo_empty", 32'(s_if.w_valid), 32'h0);
        check("post_rst_m0_w_ready", 32'(m0_if.w_ready), 32'h0);
        idle_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_mux2.md
# axi_mux2

Two-to-one AXI interconnect stage that merges two AXI masters onto one AXI port, widening the ID by one bit to record which master issued each transaction. It sits directly upstream of the ID downsizer. Its output ID is one bit wider than either input ID, and the downsizer narrows it again before the slave. AW/AR are arbitrated and forward-registered, W is steered by a grant-order FIFO, and B/R are routed back by the ID MSB.

## Interface
- W_FIFO_DEPTH, default 4: W-routing FIFO entries; power of two ≥ 2; caps AWs accepted whose W bursts are not yet complete.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m0  axi_channel.slave  interface  master port 0 (ID bit value 0)
- m1  axi_channel.slave  interface  master port 1 (ID bit value 1)
- s  axi_channel.master  interface  merged output, feeds ID downsizer
- Elaboration $fatal if s.ID_WIDTH != m0.ID_WIDTH+1 or if m0/m1 ID_WIDTH differ.
- Elaboration $fatal if addr, data or any user widths differ between ports.

## Operation
- AW path: one output register (aw_full + payload).
  - Register may load when !aw_full || s.aw_ready, and the W FIFO is not full.
  - When the register may load, the arbiter grants one requesting m_k.aw_valid; only m_k.aw_ready=1, combinationally, in that cycle.
  - On the handshake the register loads all AW fields plus s.aw_id={k, m_k.aw_id}, and k is pushed into the W FIFO.
- s.aw_valid = aw_full.
- W path: with the FIFO non-empty, head k selects the source.
  - s.w_valid = m_k.w_valid; m_k.w_ready = s.w_ready; the other master's w_ready = 0.
  - With the FIFO empty, s.w_valid = 0 and both w_ready = 0.
  - Pop on an s.w handshake with w_last=1.
- B path: k = s.b_id MSB; m_k.b_valid = s.b_valid; m_k.b_id = s.b_id[ID-2:0]; resp/user passed through; s.b_ready = m_k.b_ready; other b_valid = 0.
- AR path: identical to AW, with its own arbiter and register and no FIFO condition.
- R path: identical to B, routed by the s.r_id MSB; r_last/data/resp/user passed through.
- Arbitration: on each channel, the grant goes to the sole requester; on a tie it goes to the current priority holder (see Configuration).
- Arbitration is evaluated only when the register may load, so a granted master sees ready and valid in the same cycle.
- No outstanding-transaction tracking; ordering per ID is preserved because each master maps to a disjoint ID half.

## Timing
- Reset values: s.aw_valid=0, s.ar_valid=0, s.w_valid=0, s.b_ready=0, s.r_ready=0, all m_k ready/valid=0.
- Reset state: FIFO empty, priority pointers = m0, payload registers = 0.
- AW/AR latency is 1 cycle; throughput is 1 per cycle with back-to-back loads while s accepts.
- W, B and R paths are combinational, with 0 latency.
- W data may reach s one cycle before its AW is presented on s; this is AXI-legal.
- Boundary: FIFO full blocks both aw_ready even if a pop occurs in the same cycle (no push-on-pop-when-full).
- Boundary: push and pop in the same cycle with the FIFO neither full nor empty leaves the count unchanged.
- Boundary: FIFO pointers wrap modulo W_FIFO_DEPTH.
- Boundary: aw_full held while s.aw_ready=0 keeps the payload stable (AXI valid stability).
- Reset mid-burst discards all state; the bench must also reset masters and slave.

## Configuration
- AXI_MUX2_RR_EN defined: per-channel round-robin. After a grant to k, that channel's priority pointer becomes 1-k.
- AXI_MUX2_RR_EN undefined: fixed priority. m0 always wins ties, and the pointer logic is not generated.

## Test plan
- Single write: m1 AW id=3 len=1, then 2 W beats; B returned with s.b_id={1,3}.
  - s.aw_id={1,3} appears 1 cycle after the handshake.
  - Both W beats reach s from m1.
  - m1.b_valid=1 with b_id=3, and m0.b_valid=0.
- Tie: both masters hold AW valid for 4 cycles with s.aw_ready=1.
  - With RR_EN, grants alternate m0,m1,m0,m1.
  - Without RR_EN, all 4 grants go to m0.
- FIFO full: W_FIFO_DEPTH=4, four AWs accepted with no W issued.
  - The fifth AW is stalled (aw_ready=0) until the first w_last handshake.
  - The fifth AW is accepted in the cycle after that handshake.
- W steering: AW order m0,m1,m0 with interleaved W valids from both masters.
  - s receives W bursts strictly in order m0,m1,m0.
  - The non-head master's w_ready stays 0.
- R routing: s returns r_id {0,5} and {1,5}, 3 beats each, interleaved.
  - Each beat appears only on the matching master with r_id=5.
  - r_last is asserted only on the 3rd beat of each burst.
- Backpressure and reset: s.ar_ready=0 for 5 cycles, then rstn pulsed low mid-stall.
  - During the stall, s.ar_valid stays 1 with a stable payload.
  - After reset, all valids are 0 and the FIFO is empty.
